key_debounce: RTL

Multi-channel debouncer and single-pulse generator for the lab board's mechanical keys and slide switches. It feeds the flip-flop stages downstream:
- the debounced `level` bits drive data inputs such as J/K;
- the one-cycle `press` pulse gives a clean clock or enable event per key actuation.

Each channel filters contact bounce with a saturating stability counter behind a 2-flop synchroniser.

---
 rtl/key_debounce_pkg.sv | 17 +
 rtl/key_debounce_ch.sv | 92 +++++++++
 rtl/key_debounce.sv | 32 +++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: per-channel FSM encoding and
// the stability-counter width helper.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_t;

  // A 1-cycle filter still needs a 1-bit counter, hence the floor of 1.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: polarity fix, 2-flop synchroniser, saturating
// stability counter and a level/press/release FSM with registered outputs.
//
//   state     | meaning
//   STABLE_LO | level=0 accepted, watching for s2=1
//   WAIT_HI   | s2=1 seen, counting consecutive 1 samples
//   STABLE_HI | level=1 accepted, watching for s2=0
//   WAIT_LO   | s2=0 seen, counting consecutive 0 samples
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int            CW      = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic          k;
  logic          s1, s2;
  logic [CW-1:0] cnt;
  db_state_t     state;

  assign k = key_raw ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      cnt           <= '0;
      state         <= STABLE_LO;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= k;
      s2            <= s1;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (s2) begin
            state <= WAIT_HI;
            cnt   <= '0;
          end
        end
        WAIT_HI: begin
          if (!s2) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= STABLE_HI;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!s2) begin
            state <= WAIT_LO;
            cnt   <= '0;
          end
        end
        WAIT_LO: begin
          if (s2) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state         <= STABLE_LO;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key debouncer: N_KEYS independent key_debounce_ch instances.
// The falling-edge pulse port is release_pulse because release is a reserved word.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS        = 3,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] level,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] release_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .key_raw       (key_raw[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule
